// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer slice.
//   BT_*      : branch prediction tags carried with each entry
//   REG_W     : architectural register address width
//   XLEN      : datapath width
//   ROB_DEPTH : default number of buffer entries (power of two)
//   ROB_ID_W  : default tag width, log2(ROB_DEPTH)
package reorder_buffer_pkg;

    localparam int unsigned REG_W     = 5;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned ROB_DEPTH = 32;
    localparam int unsigned ROB_ID_W  = 5;

    localparam logic [1:0] BT_NONE   = 2'b00;
    localparam logic [1:0] BT_TAKEN  = 2'b01;
    localparam logic [1:0] BT_NTAKEN = 2'b10;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer feeding the commit stage.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   flush_i              : misprediction flush, empties the buffer
//   alloc_en_i/regaddr/branch_tag : dispatch allocation request
//   alloc_id_o           : tag handed to this cycle's allocation (tail)
//   full_o               : buffer holds DEPTH entries
//   wb0_* / wb1_*        : ALU / LSU writeback by tag
//   en_o .. cond_o       : registered commit of the oldest completed entry
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH,
    parameter int unsigned ID_W  = ROB_ID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              alloc_en_i,
    input  logic [REG_W-1:0]  alloc_regaddr_i,
    input  logic [1:0]        alloc_branch_tag_i,
    output logic [ID_W-1:0]   alloc_id_o,
    output logic              full_o,
    input  logic              wb0_en_i,
    input  logic [ID_W-1:0]   wb0_id_i,
    input  logic [XLEN-1:0]   wb0_data_i,
    input  logic [XLEN-1:0]   wb0_pc_i,
    input  logic              wb0_cond_i,
    input  logic              wb1_en_i,
    input  logic [ID_W-1:0]   wb1_id_i,
    input  logic [XLEN-1:0]   wb1_data_i,
    input  logic [XLEN-1:0]   wb1_pc_i,
    input  logic              wb1_cond_i,
    output logic              en_o,
    output logic [REG_W-1:0]  regaddr_o,
    output logic [ID_W-1:0]   id_o,
    output logic [XLEN-1:0]   data_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [1:0]        branch_tag_o,
    output logic              cond_o
);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] ready;
    logic [REG_W-1:0] regaddr_q [DEPTH];
    logic [1:0]       btag_q    [DEPTH];
    logic [XLEN-1:0]  data_q    [DEPTH];
    logic [XLEN-1:0]  pc_q      [DEPTH];
    logic [DEPTH-1:0] cond_q;

    logic [ID_W-1:0]  head;
    logic [ID_W-1:0]  tail;
    logic [ID_W:0]    count;

    logic do_alloc;
    logic do_pop;
    logic wb0_hit;
    logic wb1_hit;

    assign alloc_id_o = tail;
    // Registered count only: a pop on the same edge cannot free a slot early.
    assign full_o     = (count == (ID_W+1)'(DEPTH));

    // Flush gates every state-changing action for the cycle.
    assign do_alloc = alloc_en_i && !full_o && !flush_i;
    assign do_pop   = valid[head] && ready[head] && !flush_i;
    assign wb0_hit  = wb0_en_i && valid[wb0_id_i] && !flush_i;
    assign wb1_hit  = wb1_en_i && valid[wb1_id_i] && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid        <= '0;
            ready        <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            en_o         <= 1'b0;
            regaddr_o    <= '0;
            id_o         <= '0;
            data_o       <= '0;
            pc_o         <= '0;
            branch_tag_o <= '0;
            cond_o       <= 1'b0;
        end else if (flush_i) begin
            valid        <= '0;
            ready        <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            en_o         <= 1'b0;
            regaddr_o    <= '0;
            id_o         <= '0;
            data_o       <= '0;
            pc_o         <= '0;
            branch_tag_o <= '0;
            cond_o       <= 1'b0;
        end else begin
            if (do_alloc) begin
                valid[tail] <= 1'b1;
                ready[tail] <= 1'b0;
                tail        <= tail + ID_W'(1);
            end
            // The tail slot is invalid while being allocated, so a
            // writeback cannot collide with the alloc clearing ready.
            if (wb0_hit) ready[wb0_id_i] <= 1'b1;
            if (wb1_hit) ready[wb1_id_i] <= 1'b1;

            if (do_pop) begin
                valid[head]  <= 1'b0;
                head         <= head + ID_W'(1);
                en_o         <= 1'b1;
                regaddr_o    <= regaddr_q[head];
                id_o         <= head;
                data_o       <= data_q[head];
                pc_o         <= pc_q[head];
                branch_tag_o <= btag_q[head];
                cond_o       <= cond_q[head];
            end else begin
                en_o         <= 1'b0;
                regaddr_o    <= '0;
                id_o         <= '0;
                data_o       <= '0;
                pc_o         <= '0;
                branch_tag_o <= '0;
                cond_o       <= 1'b0;
            end

            case ({do_alloc, do_pop})
                2'b10:   count <= count + (ID_W+1)'(1);
                2'b01:   count <= count - (ID_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; valid/ready qualify every read.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            regaddr_q[tail] <= alloc_regaddr_i;
            btag_q[tail]    <= alloc_branch_tag_i;
        end
        if (wb0_hit) begin
            data_q[wb0_id_i] <= wb0_data_i;
            pc_q[wb0_id_i]   <= wb0_pc_i;
            cond_q[wb0_id_i] <= wb0_cond_i;
        end
        if (wb1_hit) begin
            data_q[wb1_id_i] <= wb1_data_i;
            pc_q[wb1_id_i]   <= wb1_pc_i;
            cond_q[wb1_id_i] <= wb1_cond_i;
        end
    end

endmodule
